// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic controller light outputs.
// Tracks the phase sequence and latches a sticky fault code on the first
// illegal encoding, conflict, illegal transition or wrong phase length.
// Ports:
//   clk            - system clock, rising edge
//   i_maintenance  - synchronous active-high reset
//   i_light_ns/ew  - direction lights: 010 green, 110 yellow, 100 red
//   i_light_ped    - pedestrian walk light
//   o_fault        - sticky fault flag
//   o_fault_code   - first fault code, 0 = none
//   o_phase        - tracked phase (0 NS_G .. 5 PED_BLINK)
//   o_round_count  - completed traffic rounds, wrapping
module traffic_light_monitor #(
    parameter int CYCLES_PER_SEC = 16,
    parameter int GREEN_SEC      = 3,
    parameter int YELLOW_SEC     = 2,
    parameter int PED_ON_SEC     = 2,
    parameter int PED_BLINK_SEC  = 2
) (
    input  logic       clk,
    input  logic       i_maintenance,
    input  logic [2:0] i_light_ns,
    input  logic [2:0] i_light_ew,
    input  logic       i_light_ped,
    output logic       o_fault,
    output logic [3:0] o_fault_code,
    output logic [2:0] o_phase,
    output logic [7:0] o_round_count
);

    localparam int QTR   = CYCLES_PER_SEC / 4;
    localparam int L_G   = GREEN_SEC * CYCLES_PER_SEC;
    localparam int L_Y   = YELLOW_SEC * CYCLES_PER_SEC;
    localparam int L_PON = PED_ON_SEC * CYCLES_PER_SEC;
    localparam int L_PBL = PED_BLINK_SEC * CYCLES_PER_SEC;
    localparam int L_M1  = (L_G > L_Y) ? L_G : L_Y;
    localparam int L_M2  = (L_PON > L_PBL) ? L_PON : L_PBL;
    localparam int L_MAX = (L_M1 > L_M2) ? L_M1 : L_M2;
    // Room for L_MAX + 1 so the over-length compare never wraps.
    localparam int CW    = $clog2(L_MAX + 2);

    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b110;
    localparam logic [2:0] RED = 3'b100;

    typedef enum logic [2:0] {
        NS_G      = 3'd0,
        NS_Y      = 3'd1,
        EW_G      = 3'd2,
        EW_Y      = 3'd3,
        PED_ON    = 3'd4,
        PED_BLINK = 3'd5
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic [3:0]    code_q, code_d;
    logic [7:0]    round_q, round_d;

    function automatic logic [6:0] pattern(phase_e ph, logic pb);
        case (ph)
            NS_G:      return {GRN, RED, 1'b0};
            NS_Y:      return {YEL, RED, 1'b0};
            EW_G:      return {RED, GRN, 1'b0};
            EW_Y:      return {RED, YEL, 1'b0};
            PED_ON:    return {RED, RED, 1'b1};
            PED_BLINK: return {RED, RED, pb};
            default:   return {RED, RED, 1'b0};
        endcase
    endfunction

    function automatic logic enc_ok(logic [2:0] x);
        return (x == GRN) || (x == YEL) || (x == RED);
    endfunction

    logic [6:0]    sample;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] half_idx;
    logic          blink_p;
    logic [CW-1:0] len;
    logic [3:0]    dcode;
    phase_e        succ_a, succ_b;
    logic          has_b;
    logic          cur_hit, hit_a, hit_b;
    logic          any_go;

    assign sample   = {i_light_ns, i_light_ew, i_light_ped};
    assign cnt_inc  = cnt_q + CW'(1);
    // Blink level for the sample at cnt_q+1: ((cnt-1) / QTR) mod 2.
    assign half_idx = cnt_q / CW'(QTR);
    assign blink_p  = half_idx[0];
    assign any_go   = (i_light_ns != RED) || (i_light_ew != RED);

    always_comb begin
        len    = CW'(L_G);
        dcode  = 4'd5;
        succ_a = NS_Y;
        succ_b = NS_Y;
        has_b  = 1'b0;
        case (phase_q)
            NS_G: begin
                succ_a = NS_Y;
            end
            NS_Y: begin
                len    = CW'(L_Y);
                dcode  = 4'd6;
                succ_a = EW_G;
            end
            EW_G: begin
                succ_a = EW_Y;
            end
            EW_Y: begin
                len    = CW'(L_Y);
                dcode  = 4'd6;
                succ_a = NS_G;
                succ_b = PED_ON;
                has_b  = 1'b1;
            end
            PED_ON: begin
                len    = CW'(L_PON);
                dcode  = 4'd7;
                succ_a = PED_BLINK;
            end
            default: begin
                len    = CW'(L_PBL);
                dcode  = 4'd7;
                succ_a = NS_G;
            end
        endcase
    end

    // Successor patterns are compared at cnt = 1, where the blink is off.
    assign cur_hit = (sample == pattern(phase_q, blink_p));
    assign hit_a   = (sample == pattern(succ_a, 1'b0));
    assign hit_b   = has_b && (sample == pattern(succ_b, 1'b0));

    always_ff @(posedge clk) begin
        if (i_maintenance) begin
            phase_q <= NS_G;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            code_q  <= 4'd0;
            round_q <= 8'd0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        code_d  = code_q;
        round_d = round_q;
        if (!fault_q) begin
            // Faulting samples leave phase, cnt and round untouched.
            if (!enc_ok(i_light_ns) || !enc_ok(i_light_ew)) begin
                code_d = 4'd1;
            end else if ((i_light_ns != RED) && (i_light_ew != RED)) begin
                code_d = 4'd2;
            end else if (i_light_ped && any_go) begin
                code_d = 4'd3;
            end else if (cur_hit) begin
                if (cnt_inc > len) begin
                    code_d = dcode;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (hit_a || hit_b) begin
                if (cnt_q != len) begin
                    code_d = dcode;
                end else begin
                    phase_d = hit_a ? succ_a : succ_b;
                    cnt_d   = CW'(1);
                    if (phase_d == NS_G) begin
                        round_d = round_q + 8'd1;
                    end
                end
            end else if ((phase_q == PED_BLINK) && (i_light_ped != blink_p)) begin
                code_d = 4'd7;
            end else begin
                code_d = 4'd4;
            end
            fault_d = (code_d != 4'd0);
        end
    end

    always_comb begin
        o_fault       = fault_q;
        o_fault_code  = code_q;
        o_phase       = phase_q;
        o_round_count = round_q;
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed + randomized bench for traffic_light_monitor.
// A phase-table reference model predicts every output each cycle.
module tb_traffic_light_monitor;

    localparam int CPS = 16;
    localparam logic [2:0] G = 3'b010;
    localparam logic [2:0] Y = 3'b110;
    localparam logic [2:0] R = 3'b100;

    logic       clk;
    logic       i_maintenance;
    logic [2:0] i_light_ns;
    logic [2:0] i_light_ew;
    logic       i_light_ped;
    logic       o_fault;
    logic [3:0] o_fault_code;
    logic [2:0] o_phase;
    logic [7:0] o_round_count;

    int checks   = 0;
    int failures = 0;

    traffic_light_monitor #(
        .CYCLES_PER_SEC(CPS),
        .GREEN_SEC(3),
        .YELLOW_SEC(2),
        .PED_ON_SEC(2),
        .PED_BLINK_SEC(2)
    ) dut (
        .clk(clk),
        .i_maintenance(i_maintenance),
        .i_light_ns(i_light_ns),
        .i_light_ew(i_light_ew),
        .i_light_ped(i_light_ped),
        .o_fault(o_fault),
        .o_fault_code(o_fault_code),
        .o_phase(o_phase),
        .o_round_count(o_round_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase table, lengths, duration codes, successors.
    int LEN [6] = '{3*CPS, 2*CPS, 3*CPS, 2*CPS, 2*CPS, 2*CPS};
    int DC  [6] = '{5, 6, 5, 6, 7, 7};
    int SUCC[6][2] = '{'{1, -1}, '{2, -1}, '{3, -1},
                       '{0, 4}, '{5, -1}, '{0, -1}};
    int m_phase, m_cnt, m_round, m_code;
    bit m_fault;

    function automatic logic [6:0] pat(int ph, int c);
        logic pb;
        pb = 1'(((c - 1) / (CPS / 4)) % 2);
        case (ph)
            0: return {G, R, 1'b0};
            1: return {Y, R, 1'b0};
            2: return {R, G, 1'b0};
            3: return {R, Y, 1'b0};
            4: return {R, R, 1'b1};
            default: return {R, R, pb};
        endcase
    endfunction

    function automatic bit ok(logic [2:0] x);
        return (x == G) || (x == Y) || (x == R);
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] ns,
                              input logic [2:0] ew, input logic ped);
        logic [6:0] s, pp;
        int code, nxt;
        s = {ns, ew, ped};
        code = 0;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_round = 0;
            m_fault = 0; m_code = 0;
        end else if (!m_fault) begin
            if (!ok(ns) || !ok(ew)) code = 1;
            else if (ns != R && ew != R) code = 2;
            else if (ped && (ns != R || ew != R)) code = 3;
            else if (s == pat(m_phase, m_cnt + 1)) begin
                if (m_cnt + 1 > LEN[m_phase]) code = DC[m_phase];
                else m_cnt++;
            end else begin
                nxt = -1;
                for (int j = 0; j < 2; j++)
                    if (SUCC[m_phase][j] >= 0 && s == pat(SUCC[m_phase][j], 1))
                        nxt = SUCC[m_phase][j];
                if (nxt >= 0) begin
                    if (m_cnt != LEN[m_phase]) code = DC[m_phase];
                    else begin
                        if (nxt == 0) m_round = (m_round + 1) % 256;
                        m_phase = nxt;
                        m_cnt = 1;
                    end
                end else begin
                    pp = pat(5, m_cnt + 1);
                    code = (m_phase == 5 && ped != pp[0]) ? 7 : 4;
                end
            end
            if (code != 0) begin
                m_fault = 1;
                m_code = code;
            end
        end
    endtask

    task automatic check_all();
        checks++;
        assert (o_fault === m_fault) else begin
            failures++;
            $error("FAIL fault got=%0d exp=%0d", o_fault, m_fault);
        end
        checks++;
        assert (o_fault_code === 4'(m_code)) else begin
            failures++;
            $error("FAIL code got=%0d exp=%0d", o_fault_code, m_code);
        end
        checks++;
        assert (o_phase === 3'(m_phase)) else begin
            failures++;
            $error("FAIL phase got=%0d exp=%0d", o_phase, m_phase);
        end
        checks++;
        assert (o_round_count === 8'(m_round)) else begin
            failures++;
            $error("FAIL round got=%0d exp=%0d", o_round_count, m_round);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] ns,
                        input logic [2:0] ew, input logic ped);
        i_maintenance = rst;
        i_light_ns = ns;
        i_light_ew = ew;
        i_light_ped = ped;
        @(posedge clk);
        model_step(rst, ns, ew, ped);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [2:0] ns, input logic [2:0] ew,
                        input logic ped, input int n);
        for (int k = 0; k < n; k++) step(1'b0, ns, ew, ped);
    endtask

    task automatic do_reset();
        step(1'b1, 3'($urandom), 3'($urandom), 1'($urandom));
        step(1'b1, 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic blink(input int half, input int reps);
        for (int k = 0; k < reps; k++) begin
            hold(R, R, 1'b0, half);
            hold(R, R, 1'b1, half);
        end
    endtask

    task automatic round_legal(input bit with_ped);
        hold(G, R, 1'b0, 48);
        hold(Y, R, 1'b0, 32);
        hold(R, G, 1'b0, 48);
        hold(R, Y, 1'b0, 32);
        if (with_ped) begin
            hold(R, R, 1'b1, 32);
            blink(4, 4);
        end
    endtask

    task automatic sticky(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic expect_k(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [2:0] bad_enc [5] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111};
    int n_rounds;

    initial begin
        i_maintenance = 1'b1;
        i_light_ns = R;
        i_light_ew = R;
        i_light_ped = 1'b0;
        m_phase = 0; m_cnt = 0; m_round = 0; m_fault = 0; m_code = 0;

        // Reset state, then one plain round.
        do_reset();
        expect_k("rst_fault", int'(o_fault), 0);
        expect_k("rst_phase", int'(o_phase), 0);
        expect_k("rst_round", int'(o_round_count), 0);
        round_legal(1'b0);
        expect_k("ew_y_phase", int'(o_phase), 3);
        hold(G, R, 1'b0, 3);
        expect_k("round1", int'(o_round_count), 1);
        expect_k("round1_fault", int'(o_fault), 0);

        // Pedestrian round.
        do_reset();
        hold(G, R, 1'b0, 48);
        hold(Y, R, 1'b0, 32);
        hold(R, G, 1'b0, 48);
        hold(R, Y, 1'b0, 32);
        hold(R, R, 1'b1, 32);
        expect_k("ped_on_phase", int'(o_phase), 4);
        blink(4, 4);
        expect_k("blink_phase", int'(o_phase), 5);
        hold(G, R, 1'b0, 1);
        expect_k("ped_round", int'(o_round_count), 1);
        expect_k("ped_fault", int'(o_fault), 0);

        // Random mix of plain and pedestrian rounds.
        do_reset();
        n_rounds = $urandom_range(2, 4);
        for (int r = 0; r < n_rounds; r++) round_legal(1'($urandom));
        hold(G, R, 1'b0, 1);
        expect_k("rand_rounds", int'(o_round_count), n_rounds);

        // Short and long green.
        do_reset();
        hold(G, R, 1'b0, 47);
        hold(Y, R, 1'b0, 1);
        expect_k("short_green", int'(o_fault_code), 5);
        sticky(100);
        expect_k("short_sticky", int'(o_fault_code), 5);
        do_reset();
        hold(G, R, 1'b0, 49);
        expect_k("long_green", int'(o_fault_code), 5);

        // Conflict, bad encoding, ped during green.
        do_reset();
        hold(G, R, 1'b0, 9);
        expect_k("pre_conflict", int'(o_fault), 0);
        hold(G, G, 1'b0, 1);
        expect_k("conflict", int'(o_fault_code), 2);
        sticky(100);
        expect_k("conflict_sticky", int'(o_fault), 1);
        do_reset();
        hold(3'b111, R, 1'b0, 1);
        expect_k("enc_111", int'(o_fault_code), 1);
        sticky(100);
        do_reset();
        hold(G, R, 1'b0, $urandom_range(1, 40));
        hold(R, bad_enc[$urandom_range(0, 4)], 1'b0, 1);
        expect_k("enc_rand", int'(o_fault_code), 1);
        do_reset();
        hold(G, R, 1'b0, 5);
        hold(G, R, 1'b1, 1);
        expect_k("ped_green", int'(o_fault_code), 3);
        sticky(100);

        // Illegal jump and bad blink half-period.
        do_reset();
        hold(G, R, 1'b0, 48);
        hold(R, G, 1'b0, 1);
        expect_k("jump", int'(o_fault_code), 4);
        do_reset();
        hold(G, R, 1'b0, 48);
        hold(Y, R, 1'b0, 32);
        hold(R, G, 1'b0, 48);
        hold(R, Y, 1'b0, 32);
        hold(R, R, 1'b1, 32);
        blink(3, 2);
        expect_k("blink3", int'(o_fault_code), 7);

        // Fault in PED_ON, reset mid-phase, then a clean round.
        do_reset();
        hold(G, R, 1'b0, 48);
        hold(Y, R, 1'b0, 32);
        hold(R, G, 1'b0, 48);
        hold(R, Y, 1'b0, 32);
        hold(R, R, 1'b1, 10);
        hold(3'b111, R, 1'b1, 1);
        hold(R, R, 1'b1, 5);
        step(1'b1, R, R, 1'b1);
        expect_k("mid_rst_fault", int'(o_fault), 0);
        expect_k("mid_rst_phase", int'(o_phase), 0);
        round_legal(1'b1);
        hold(G, R, 1'b0, 2);
        expect_k("fresh_round", int'(o_round_count), 1);
        expect_k("fresh_fault", int'(o_fault), 0);

        // Randomized phase lengths around the legal values.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            hold(G, R, 1'b0, $urandom_range(46, 50));
            hold(Y, R, 1'b0, $urandom_range(31, 33));
            hold(R, G, 1'b0, $urandom_range(47, 49));
            hold(R, Y, 1'b0, $urandom_range(31, 33));
            hold(R, R, 1'b1, $urandom_range(31, 33));
            blink($urandom_range(3, 5), 4);
            hold(G, R, 1'b0, 2);
            sticky(20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the light outputs of the traffic FSM. It receives the NS, EW and pedestrian light signals and tracks the expected phase sequence.
- It raises a sticky fault with a code on the first illegal encoding, conflicting light combination, illegal transition or wrong phase duration.
- It sits beside the controller in the intersection top level and drives the maintenance/fault indicator.

Parameters:
- CYCLES_PER_SEC, 16: clock cycles per second. Must be a multiple of 4 and at least 4.
- GREEN_SEC, 3: green duration per direction, in seconds.
- YELLOW_SEC, 2: yellow duration per direction, in seconds.
- PED_ON_SEC, 2: solid pedestrian-on duration, in seconds.
- PED_BLINK_SEC, 2: pedestrian blink duration, in seconds. Blink half-period is CYCLES_PER_SEC/4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- i_maintenance  input  1  reset: synchronous, active-high; the same signal that resets the controller.
- i_light_ns  input  3  NS light. 3'b010 = green, 3'b110 = yellow, 3'b100 = red.
- i_light_ew  input  3  EW light, same encoding as i_light_ns.
- i_light_ped  input  1  pedestrian light, 1 = walk on.
- o_fault  output  1  sticky fault flag.
- o_fault_code  output  4  code of the first fault; 0 = none.
- o_phase  output  3  tracked phase: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y, 4 PED_ON, 5 PED_BLINK.
- o_round_count  output  8  completed traffic rounds, wraps 255 -> 0.

Behaviour:
- Reset (i_maintenance = 1 at a clock edge):
  - o_fault = 0, o_fault_code = 0, o_phase = NS_G, o_round_count = 0.
  - Internal phase counter cnt = 0. No checks are performed during reset.
- Sampling:
  - Each non-reset cycle samples the inputs once.
  - cnt = number of samples taken in the current phase, including the current sample.
  - The first sample after reset belongs to NS_G with cnt = 1.
- Expected patterns (ns / ew / ped):
  - NS_G: 010 / 100 / 0.
  - NS_Y: 110 / 100 / 0.
  - EW_G: 100 / 010 / 0.
  - EW_Y: 100 / 110 / 0.
  - PED_ON: 100 / 100 / 1.
  - PED_BLINK: 100 / 100 / p, where p = ((cnt-1) / (CYCLES_PER_SEC/4)) mod 2. The blink starts with ped off.
- Legal successors:
  - NS_G -> NS_Y -> EW_G -> EW_Y.
  - EW_Y -> NS_G, or EW_Y -> PED_ON.
  - PED_ON -> PED_BLINK -> NS_G.
  - PED_ON -> PED_BLINK is recognised by ped = 0 with both directions red.
- Phase lengths L: green = GREEN_SEC*CPS, yellow = YELLOW_SEC*CPS, PED_ON = PED_ON_SEC*CPS, PED_BLINK = PED_BLINK_SEC*CPS.
- Per-sample evaluation, first matching rule only; fault codes in priority order:
  1. Either light field is not 010/110/100 -> code 1.
  2. NS and EW both non-red -> code 2.
  3. Ped = 1 while either direction is non-red -> code 3.
  4. Sample matches the current pattern: cnt increments. If the new cnt > L -> code 5 (green), 6 (yellow) or 7 (ped phases).
  5. Sample matches a legal successor pattern: if cnt != L -> same duration code as rule 4. Otherwise advance phase and set cnt = 1.
  6. Otherwise, illegal transition -> code 4. In PED_BLINK a ped value that mismatches p gives code 7 instead.
- Fault latency: o_fault and o_fault_code are registered and appear the cycle after the offending sample.
- After a fault:
  - o_fault stays 1, o_fault_code is frozen, and o_phase, cnt and o_round_count freeze.
  - Only reset clears it.
- Round count: o_round_count increments on each NS_G entry from EW_Y or PED_BLINK.
- Reset mid-phase: reset has priority over every event in the same cycle and returns to NS_G with cnt = 0.
- Implementation constraints: cnt is wide enough for the largest L + 1 with no overflow. No combinational path from inputs to outputs.

Test Plan:
- Reset, then a legal NS_G 48 / NS_Y 32 / EW_G 48 / EW_Y 32 sequence, then NS_G (CPS = 16) -> o_fault = 0, o_phase follows 0,1,2,3,0, o_round_count = 1.
- EW_Y, then PED_ON 32 cycles, then blink off 4 / on 4 repeated 4 times, then NS_G -> no fault, o_phase visits 4, 5, 0, o_round_count increments.
- NS_G held for only 47 cycles before yellow -> o_fault = 1, code 5 the cycle after the first yellow sample. Holding green for 49 cycles also gives code 5.
- ns = 010 with ew = 010 at cycle 10 -> code 2. ns = 3'b111 -> code 1. Ped = 1 during NS_G -> code 3. Each case is checked from reset, and the fault stays sticky for 100+ cycles.
- NS_G jumping straight to EW_G at cycle 48 -> code 4. A blink half-period of 3 cycles instead of 4 -> code 7.
- Reset mid-PED_ON after a fault -> outputs cleared, o_phase = NS_G, and a fresh legal sequence passes with no fault.
